xge_wb_cfg_arbiter: RTL and testbench
=====================================

# xge_wb_cfg_arbiter

Two-port Wishbone master arbiter that shares the MAC's single Wishbone register slave (8-bit address, 32-bit data) between two configuration requesters, e.g. the host config path and the statistics poller. It grants one request at a time in round-robin order, runs one classic single-beat Wishbone cycle, and returns read data or a timeout error to the requester. It sits between the requesters and the MAC `wb_*` slave pins.

## Interface
Clock `wb_clk_i`; reset `wb_rst_n_i`, asynchronous, active-low.

Parameters:
- `AW`, 8, Wishbone address width
- `DW`, 32, Wishbone data width
- `TIMEOUT_CYCLES`, 16, maximum strobe cycles waiting for ack (≥1)

Ports:
- `wb_clk_i`  in  1  clock
- `wb_rst_n_i`  in  1  async active-low reset
- `reqN_valid_i`  in  1  request pending, N ∈ {0,1}
- `reqN_we_i`  in  1  1 = write, 0 = read
- `reqN_adr_i`  in  AW  register address
- `reqN_dat_i`  in  DW  write data
- `reqN_ready_o`  out  1  request accepted this cycle
- `rspN_valid_o`  out  1  one-cycle response pulse
- `rspN_dat_o`  out  DW  read data; 0 on write or error
- `rspN_err_o`  out  1  timeout flag, valid with `rspN_valid_o`
- `wb_adr_o`  out  AW  to slave `wb_adr_i`
- `wb_dat_o`  out  DW  to slave `wb_dat_i`
- `wb_we_o`  out  1  to slave `wb_we_i`
- `wb_cyc_o`  out  1  to slave `wb_cyc_i`
- `wb_stb_o`  out  1  to slave `wb_stb_i`
- `wb_ack_i`  in  1  from slave `wb_ack_o`
- `wb_dat_i`  in  DW  from slave `wb_dat_o`

## Operation
- States: IDLE, BUS.
- IDLE:
  - With any `reqN_valid_i` high, pick a winner.
  - Assert its `reqN_ready_o` combinationally in the same cycle.
  - Latch we/adr/dat and the winner index.
  - Go to BUS.
- Arbitration is round-robin on `last_grant`:
  - Both valid: grant the port ≠ `last_grant`.
  - One valid: grant it.
  - `last_grant` resets to 1, so port 0 wins the first contention.
- BUS:
  - `wb_cyc_o`/`wb_stb_o` high; adr/dat/we held stable from registers.
  - Timer starts at 1 on the first BUS cycle and increments each cycle without ack.
  - `wb_ack_i` high: capture `wb_dat_i` if read, go to IDLE.
  - Timer == `TIMEOUT_CYCLES` with no ack: abort, set err, go to IDLE.
  - An ack on the `TIMEOUT_CYCLES`-th cycle counts as success.
- Response:
  - `rspN_valid_o` pulses for one cycle, on the winner's port only, in the cycle after ack/abort.
  - Data is 0 for writes and on error.
- `wb_ack_i` outside BUS is ignored.
- Requesters must hold valid/we/adr/dat until ready. Dropping valid before ready is permitted and simply withdraws the request.
- Reset at any point:
  - All outputs go low immediately.
  - Any in-flight transaction is discarded with no response.
  - State returns to IDLE, `last_grant` returns to 1.

## Timing
- Reset values: all outputs 0, state IDLE, timer 0, `last_grant`=1.
- Accept at cycle T means:
  - `wb_stb_o` high T+1 … T+1+k, with ack seen at T+1+k.
  - `wb_cyc_o`/`wb_stb_o` low at T+2+k.
  - `rspN_valid_o` high at T+2+k.
- State is IDLE at T+2+k, so the next accept can happen at T+2+k. The strobe is therefore low for at least one cycle between transactions.
- Best case is 2 cycles accept-to-response (zero-wait ack). Timeout response arrives at T+1+`TIMEOUT_CYCLES`.
- `reqN_ready_o` is the only combinational output; all `wb_*` and `rsp*` outputs are registered.
- Timer width is $clog2(`TIMEOUT_CYCLES`+1) and must not wrap.

## Structure
- Package `xge_wb_arb_pkg`:
  - state enum (IDLE, BUS)
  - default timeout constant
  - error-data constant (0)
- Sub-module `xge_wb_rr_pick`: two-input round-robin picker (valid[1:0], last_grant → grant one-hot). It is combinational and instantiated once.
- Bench connects `wb_*` to the MAC slave through the existing driver/monitor interface.

## Test plan
- Single write, port 0: adr 8'h00, dat 32'h0000_0001, zero-wait ack → stb high 1 cycle, `rsp0_valid_o` at T+2, err 0, `rsp0_dat_o` 0.
- Read, port 1, 3-cycle wait: slave returns 32'hA5A5_1234 → stb high 4 cycles, `rsp1_dat_o`=32'hA5A5_1234, no pulse on port 0.
- Both ports valid continuously for 4 transactions → grants 0,1,0,1. Strobes separated by ≥1 low cycle.
- No ack, `TIMEOUT_CYCLES`=16 → stb high exactly 16 cycles, `rsp0_err_o`=1, `rsp0_dat_o`=0 at T+17. A later ack pulse is ignored.
- Ack exactly on cycle 16 → success, err 0, data captured.
- Assert `wb_rst_n_i` low mid-BUS → cyc/stb/rsp drop at once with no response. After release, port 0 wins first contention.

Source files
------------

// File: rtl/xge_wb_arb_pkg.sv
// xge_wb_arb_pkg: shared state encoding and constants for the Wishbone config arbiter
package xge_wb_arb_pkg;
  typedef enum logic {IDLE, BUS} state_t;
  localparam int DEF_TIMEOUT = 16;
  localparam int ERR_DATA = 0;
endpackage

// File: rtl/xge_wb_rr_pick.sv
// xge_wb_rr_pick: combinational two-input round-robin picker (valid[1:0], last_grant -> one-hot grant)
module xge_wb_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb grant = &valid ? (last_grant ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/xge_wb_cfg_arbiter.sv
// xge_wb_cfg_arbiter: two requesters round-robin onto one single-beat Wishbone master with ack timeout
module xge_wb_cfg_arbiter
  import xge_wb_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic          req0_valid_i,
  input  logic          req0_we_i,
  input  logic [AW-1:0] req0_adr_i,
  input  logic [DW-1:0] req0_dat_i,
  output logic          req0_ready_o,
  output logic          rsp0_valid_o,
  output logic [DW-1:0] rsp0_dat_o,
  output logic          rsp0_err_o,
  input  logic          req1_valid_i,
  input  logic          req1_we_i,
  input  logic [AW-1:0] req1_adr_i,
  input  logic [DW-1:0] req1_dat_i,
  output logic          req1_ready_o,
  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp1_dat_o,
  output logic          rsp1_err_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic [1:0] grant;
  logic last_grant, idx, accept, done;
  logic [DW-1:0] rd_dat;
  logic [TW-1:0] timer;
  xge_wb_rr_pick u_pick (
    .valid({req1_valid_i, req0_valid_i}),
    .last_grant(last_grant),
    .grant(grant)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state <= IDLE;
      last_grant <= 1'b1;
      idx <= 1'b0;
      timer <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_we_o <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_valid_o <= 1'b0;
      rsp0_err_o <= 1'b0;
      rsp1_err_o <= 1'b0;
      rsp0_dat_o <= '0;
      rsp1_dat_o <= '0;
    end else begin
      state <= state_nx;
      timer <= accept ? TW'(1) : done ? '0 : (state == BUS) ? timer + TW'(1) : timer;
      rsp0_valid_o <= done && !idx;
      rsp1_valid_o <= done && idx;
      rsp0_err_o <= done && !idx && !wb_ack_i;
      rsp1_err_o <= done && idx && !wb_ack_i;
      rsp0_dat_o <= (done && !idx) ? rd_dat : DW'(ERR_DATA);
      rsp1_dat_o <= (done && idx) ? rd_dat : DW'(ERR_DATA);
      if (accept) begin
        last_grant <= grant[1];
        idx <= grant[1];
        wb_we_o <= grant[1] ? req1_we_i : req0_we_i;
        wb_adr_o <= grant[1] ? req1_adr_i : req0_adr_i;
        wb_dat_o <= grant[1] ? req1_dat_i : req0_dat_i;
      end
    end
  always_comb state_nx = accept ? BUS : done ? IDLE : state;
  always_comb begin
    accept = wb_rst_n_i && state == IDLE && |grant;
    done = state == BUS && (wb_ack_i || timer == TW'(TIMEOUT_CYCLES));
    req0_ready_o = accept && grant[0];
    req1_ready_o = accept && grant[1];
    wb_cyc_o = state == BUS;
    wb_stb_o = state == BUS;
    rd_dat = (wb_ack_i && !wb_we_o) ? wb_dat_i : DW'(ERR_DATA);
  end
endmodule

// File: tb/tb_xge_wb_cfg_arbiter.sv
// tb_xge_wb_cfg_arbiter: transaction-level model plus directed vectors for the Wishbone config arbiter
module tb_xge_wb_cfg_arbiter;
  localparam int TO = 16;
  logic clk, rst_n;
  logic req0_valid, req0_we, req1_valid, req1_we;
  logic [7:0] req0_adr, req1_adr;
  logic [31:0] req0_dat, req1_dat;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_dat, rsp1_dat;
  logic [7:0] wb_adr;
  logic [31:0] wb_dat_out, wb_dat_in;
  logic wb_we, wb_cyc, wb_stb, wb_ack;
  int n_chk = 0, n_err = 0;
  int cyc = 0;
  int slave_delay = 0, slave_cnt = 0;
  logic [31:0] slave_data = '0;
  bit ack_force = 0;
  int free_at, stb_s, stb_e, rsp_at;
  bit last, rp, m_we, m_err;
  logic [7:0] m_adr;
  logic [31:0] m_dat, m_rdat;
  int n_acc = 0, n_rsp = 0, run = 0, stb_len = 0, acc_cyc = 0, rsp_cyc = 0;
  bit rsp_port, rsp_e;
  logic [31:0] rsp_d;
  bit win_log[$];
  int acc_log[$];
  xge_wb_cfg_arbiter #(.AW(8), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .req0_valid_i(req0_valid), .req0_we_i(req0_we), .req0_adr_i(req0_adr), .req0_dat_i(req0_dat),
    .req0_ready_o(req0_ready), .rsp0_valid_o(rsp0_valid), .rsp0_dat_o(rsp0_dat), .rsp0_err_o(rsp0_err),
    .req1_valid_i(req1_valid), .req1_we_i(req1_we), .req1_adr_i(req1_adr), .req1_dat_i(req1_dat),
    .req1_ready_o(req1_ready), .rsp1_valid_o(rsp1_valid), .rsp1_dat_o(rsp1_dat), .rsp1_err_o(rsp1_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_out), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_ack_i(wb_ack), .wb_dat_i(wb_dat_in)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic void model_reset();
    free_at = 0;
    stb_s = 1;
    stb_e = 0;
    rsp_at = -1;
    last = 1;
  endfunction
  // slave: acks on strobe cycle slave_delay+1 and ignores nothing else
  always @(negedge clk) begin
    slave_cnt = wb_stb ? slave_cnt + 1 : 0;
    wb_ack = (wb_stb && slave_cnt == slave_delay + 1) || ack_force;
  end
  assign wb_dat_in = slave_data;
  always @(negedge clk) begin
    bit bus, acc, w;
    if (!rst_n) begin
      model_reset();
      chk("rst_stb", wb_stb, 0);
      chk("rst_cyc", wb_cyc, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_rsp1", rsp1_valid, 0);
      chk("rst_err", {rsp0_err, rsp1_err}, 0);
      chk("rst_bus", {wb_adr, wb_dat_out, wb_we}, 0);
    end else begin
      bus = cyc >= stb_s && cyc <= stb_e;
      chk("stb", wb_stb, bus);
      chk("cyc", wb_cyc, bus);
      if (bus) chk("bus_fields", {wb_we, wb_adr, wb_dat_out}, {m_we, m_adr, m_dat});
      chk("rsp0_valid", rsp0_valid, cyc == rsp_at && !rp);
      chk("rsp1_valid", rsp1_valid, cyc == rsp_at && rp);
      if (cyc == rsp_at) begin
        chk("rsp_dat", rp ? rsp1_dat : rsp0_dat, m_rdat);
        chk("rsp_err", rp ? rsp1_err : rsp0_err, m_err);
      end
      acc = cyc >= free_at && (req0_valid || req1_valid);
      w = (req0_valid && req1_valid) ? !last : req1_valid;
      chk("ready0", req0_ready, acc && !w);
      chk("ready1", req1_ready, acc && w);
      if (acc) begin
        last = w;
        rp = w;
        m_we = w ? req1_we : req0_we;
        m_adr = w ? req1_adr : req0_adr;
        m_dat = w ? req1_dat : req0_dat;
        stb_s = cyc + 1;
        if (slave_delay + 1 <= TO) begin
          stb_e = cyc + 1 + slave_delay;
          m_err = 0;
          m_rdat = m_we ? 32'h0 : slave_data;
        end else begin
          stb_e = cyc + TO;
          m_err = 1;
          m_rdat = 32'h0;
        end
        rsp_at = stb_e + 1;
        free_at = rsp_at;
      end
      if (req0_ready || req1_ready) begin
        n_acc++;
        acc_cyc = cyc;
        win_log.push_back(req1_ready);
        acc_log.push_back(cyc);
      end
      if (rsp0_valid || rsp1_valid) begin
        n_rsp++;
        rsp_cyc = cyc;
        rsp_port = rsp1_valid;
        rsp_d = rsp1_valid ? rsp1_dat : rsp0_dat;
        rsp_e = rsp1_valid ? rsp1_err : rsp0_err;
      end
    end
    if (wb_stb) run++;
    else if (run > 0) begin
      stb_len = run;
      run = 0;
    end
  end
  task automatic set_req(input bit p, input bit v, input bit we, input logic [7:0] adr, input logic [31:0] dat);
    if (p) begin
      req1_valid = v; req1_we = we; req1_adr = adr; req1_dat = dat;
    end else begin
      req0_valid = v; req0_we = we; req0_adr = adr; req0_dat = dat;
    end
  endtask
  task automatic issue(input bit p, input bit we, input logic [7:0] adr, input logic [31:0] dat);
    int n0;
    n0 = n_acc;
    set_req(p, 1, we, adr, dat);
    for (int i = 0; i < 50 && n_acc == n0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("accept_seen", n_acc > n0, 1);
    set_req(p, 0, 0, 8'h00, 32'h0);
  endtask
  task automatic wait_rsp(input int n0);
    for (int i = 0; i < 100 && n_rsp == n0; i++) @(posedge clk);
    #1;
    chk("rsp_seen", n_rsp > n0, 1);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int n0, base;
    rst_n = 0;
    set_req(0, 0, 0, 8'h00, 32'h0);
    set_req(1, 0, 0, 8'h00, 32'h0);
    idle(3);
    rst_n = 1;
    idle(2);
    slave_delay = 0;
    n0 = n_rsp;
    issue(0, 1, 8'h00, 32'h0000_0001);
    wait_rsp(n0);
    chk("t1_len", stb_len, 1);
    chk("t1_lat", rsp_cyc - acc_cyc, 2);
    chk("t1_port", rsp_port, 0);
    chk("t1_err", rsp_e, 0);
    chk("t1_dat", rsp_d, 32'h0);
    idle(2);
    slave_delay = 3;
    slave_data = 32'hA5A5_1234;
    n0 = n_rsp;
    issue(1, 0, 8'h10, 32'h0);
    wait_rsp(n0);
    chk("t2_len", stb_len, 4);
    chk("t2_lat", rsp_cyc - acc_cyc, 5);
    chk("t2_port", rsp_port, 1);
    chk("t2_dat", rsp_d, 32'hA5A5_1234);
    chk("t2_rsp_count", n_rsp - n0, 1);
    idle(2);
    slave_delay = 0;
    base = win_log.size();
    n0 = n_acc;
    set_req(0, 1, 1, 8'h04, 32'h0000_0011);
    set_req(1, 1, 0, 8'h08, 32'h0);
    for (int i = 0; i < 100 && n_acc < n0 + 4; i++) begin
      @(posedge clk);
      #1;
    end
    set_req(0, 0, 0, 8'h00, 32'h0);
    set_req(1, 0, 0, 8'h00, 32'h0);
    chk("t3_count", n_acc - n0, 4);
    if (win_log.size() >= base + 4)
      for (int i = 0; i < 4; i++) begin
        chk("t3_winner", win_log[base + i], i % 2);
        if (i > 0) chk("t3_spacing", acc_log[base + i] - acc_log[base + i - 1], 2);
      end
    idle(5);
    slave_delay = 1000;
    n0 = n_rsp;
    issue(0, 0, 8'h2C, 32'h0);
    wait_rsp(n0);
    chk("t4_len", stb_len, TO);
    chk("t4_lat", rsp_cyc - acc_cyc, 17);
    chk("t4_port", rsp_port, 0);
    chk("t4_err", rsp_e, 1);
    chk("t4_dat", rsp_d, 32'h0);
    ack_force = 1;
    idle(1);
    ack_force = 0;
    idle(4);
    chk("t4_late_ack", n_rsp - n0, 1);
    slave_delay = 15;
    slave_data = 32'hDEAD_BEEF;
    n0 = n_rsp;
    issue(1, 0, 8'h30, 32'h0);
    wait_rsp(n0);
    chk("t5_len", stb_len, 16);
    chk("t5_lat", rsp_cyc - acc_cyc, 17);
    chk("t5_port", rsp_port, 1);
    chk("t5_err", rsp_e, 0);
    chk("t5_dat", rsp_d, 32'hDEAD_BEEF);
    idle(2);
    slave_delay = 1000;
    issue(0, 0, 8'h40, 32'h0);
    idle(3);
    chk("t6_stb_before", wb_stb, 1);
    n0 = n_rsp;
    rst_n = 0;
    #1;
    chk("t6_stb_drop", wb_stb, 0);
    chk("t6_cyc_drop", wb_cyc, 0);
    idle(2);
    rst_n = 1;
    idle(20);
    chk("t6_no_rsp", n_rsp - n0, 0);
    slave_delay = 0;
    base = win_log.size();
    n0 = n_acc;
    set_req(0, 1, 1, 8'h50, 32'h0000_0050);
    set_req(1, 1, 1, 8'h51, 32'h0000_0051);
    for (int i = 0; i < 50 && n_acc == n0; i++) begin
      @(posedge clk);
      #1;
    end
    set_req(0, 0, 0, 8'h00, 32'h0);
    set_req(1, 0, 0, 8'h00, 32'h0);
    chk("t6_accept", n_acc - n0, 1);
    if (win_log.size() > base) chk("t6_first_winner", win_log[base], 0);
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
